// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter and the 16x receiver.
// State encoding widens to 3 bits when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE     = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int STOP_TICKS_DEF = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;
`endif

  // Bits needed to hold max_val without wrapping (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: s_tick-paced UART TX, start / LSB-first data / stop.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int numberOfDataBits = DATA_BITS_DEF,
  parameter int stopBitTicks     = STOP_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_dataIn,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_doneTick
);

  localparam int N    = numberOfDataBits;
  localparam int TMAX = (stopBitTicks > OVERSAMPLE) ?
                        stopBitTicks : OVERSAMPLE;
  localparam int TW   = cnt_w(TMAX - 1);
  localparam int BW   = cnt_w(N - 1);

  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(stopBitTicks - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N - 1);

  uart_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [TW-1:0] term;
  logic          bit_end;

  assign term    = (state_q == STOP) ? T_STOP : T_BIT;
  assign bit_end = s_tick && (tick_q == term);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE && s_tick) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = tx_dataIn[N-1:0];
          tick_d  = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_dataIn[N-1:0];
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == B_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign tx_doneTick = done_q;

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART serial transmitter; the transmit counterpart of the team's 16x-oversampling receiver, sharing its baud tick source.
- Accepts one data word via a start strobe.
- Serialises it as start bit, data bits LSB first, then stop bit, on a single line idling high.
- Runs entirely in the clk domain; s_tick is a one-clk-wide enable pulse from the shared baud generator, not a clock.

Parameters:
numberOfDataBits, 8, data bits per frame (supported 5..8).
stopBitTicks, 16, s_tick count of the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
s_tick  input  1  baud x16 enable pulse, high for exactly one clk.
tx_start  input  1  request to send tx_dataIn; sampled every clk.
tx_dataIn  input  8  word to send; only bits [numberOfDataBits-1:0] are used.
tx  output  1  serial line; idles high.
tx_busy  output  1  high while a frame is in progress.
tx_doneTick  output  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset (synchronous, active-high):
  - Takes effect at the next clk edge regardless of state, including mid-frame.
  - Outputs: tx=1, tx_busy=0, tx_doneTick=0.
  - Internal: state=IDLE, tick counter=0, bit counter=0, shift register=0.
  - A frame interrupted by reset is abandoned; no doneTick is produced for it.
- States: IDLE, START, DATA, STOP (PARITY only with the optional feature).
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_start=1: latch tx_dataIn into the shift register, clear counters, go to START.
  - tx and tx_busy are registered, so tx=0 and tx_busy=1 appear one clk after the accepting edge.
  - tx_start does not need to coincide with s_tick.
- Bit timing (all non-IDLE states):
  - The tick counter advances only on clk cycles where s_tick=1.
  - A bit ends on the s_tick where the counter reaches its terminal value; the counter then resets to 0 and the state advances.
  - Terminal value is 15 for START, DATA and PARITY; stopBitTicks-1 for STOP.
- START: tx=0 for 16 s_ticks, then go to DATA.
- DATA:
  - tx = shift register bit 0.
  - At each bit end: shift right by one and increment the bit counter.
  - After bit numberOfDataBits-1 ends, go to STOP (or PARITY).
- STOP: tx=1. At the stop bit end:
  - go to IDLE;
  - tx_doneTick=1 for exactly one clk;
  - tx_busy=0 on the same edge.
- tx_start while tx_busy=1 (including the doneTick cycle's preceding edge) is ignored; no queueing.
- Back-to-back frames:
  - tx_start asserted in the cycle tx_doneTick=1 is accepted.
  - Minimum idle between frames is one clk.
- tx_dataIn changes after acceptance do not affect the frame in flight.
- The counter widths must hold stopBitTicks-1 and numberOfDataBits-1 with no wrap.
- tx is driven from a register (glitch-free).

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even parity bit, i.e. XOR of the numberOfDataBits data bits.
  - It lasts 16 s_ticks.
  - Frame length grows by one bit.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (2-bit without parity, 3-bit with parity);
  - the localparam OVERSAMPLE=16;
  - default numberOfDataBits and stopBitTicks, so receiver and transmitter agree.
- No sub-module; the single FSM with tick counter, bit counter and shift register is small enough to stay flat.

Test Plan:
- s_tick every 4 clk, send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 64 clk ±4; tx_doneTick pulses once; tx_busy high for about 640 clk.
- tx_start held high continuously with data 0x00 then 0xFF → two consecutive frames; second start bit begins 1 clk after the first tx_doneTick; no extra frames while busy.
- tx_start pulsed mid-frame with 0x3C during a 0x81 transmission → 0x81 frame unchanged; 0x3C never sent.
- reset asserted during DATA bit 3 → tx=1 and tx_busy=0 on the next edge; no tx_doneTick; the next tx_start sends a complete fresh frame.
- stopBitTicks=32 → stop bit lasts 32 s_ticks (128 clk at tick period 4); tx_doneTick fires at its end.
- UART_TX_PARITY_EN defined, send 0xA5 then 0x07 → parity bits 0 then 1 between data and stop; loopback into the receiver yields rx_dataOut 0xA5 and 0x07.
